// File: rtl/fwd_sel_ctrl.sv
// Forwarding-select controller: tracks EX/MEM destination slots, produces registered
// operand-mux selects for the EX stage and a combinational load-use stall request.
module fwd_sel_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             load_use_stall
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  logic [REG_W-1:0] ex_rd_reg;
  logic             ex_wr_reg;
  logic             ex_ld_reg;
  logic [REG_W-1:0] mem_rd_reg;
  logic             mem_wr_reg;
  logic [1:0]       fwd_a_sel_reg;
  logic [1:0]       fwd_b_sel_reg;

  logic [REG_W-1:0] src [2];
  logic [1:0]       sel_next [2];
  logic [1:0]       ld_hit;

  assign src[0] = id_rn;
  assign src[1] = id_rm;

  // Index 0 is operand A (rn), index 1 is operand B (rm); EX (younger) wins over MEM.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic ex_match;
      logic mem_match;

      assign ex_match  = ex_wr_reg  && (ex_rd_reg  == src[gi]) && (src[gi] != ZERO_IDX);
      assign mem_match = mem_wr_reg && (mem_rd_reg == src[gi]) && (src[gi] != ZERO_IDX);
      assign ld_hit[gi] = ex_match && ex_ld_reg;

      always_comb begin
        sel_next[gi] = 2'b00;
        if (ex_match) begin
          sel_next[gi] = 2'b01;
        end else if (mem_match) begin
          sel_next[gi] = 2'b10;
        end
      end
    end
  endgenerate

  assign load_use_stall = |ld_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rd_reg     <= '0;
      ex_wr_reg     <= 1'b0;
      ex_ld_reg     <= 1'b0;
      mem_rd_reg    <= '0;
      mem_wr_reg    <= 1'b0;
      fwd_a_sel_reg <= 2'b00;
      fwd_b_sel_reg <= 2'b00;
    end else if (flush || (!stall && load_use_stall)) begin
      // Insert a bubble into EX; the older instruction still advances to MEM.
      ex_rd_reg     <= '0;
      ex_wr_reg     <= 1'b0;
      ex_ld_reg     <= 1'b0;
      mem_rd_reg    <= ex_rd_reg;
      mem_wr_reg    <= ex_wr_reg;
      fwd_a_sel_reg <= 2'b00;
      fwd_b_sel_reg <= 2'b00;
    end else if (!stall) begin
      ex_rd_reg     <= id_rd;
      ex_wr_reg     <= id_regwrite;
      ex_ld_reg     <= id_memread;
      mem_rd_reg    <= ex_rd_reg;
      mem_wr_reg    <= ex_wr_reg;
      fwd_a_sel_reg <= sel_next[0];
      fwd_b_sel_reg <= sel_next[1];
    end
  end

  assign fwd_a_sel = fwd_a_sel_reg;
  assign fwd_b_sel = fwd_b_sel_reg;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: hand-computed selects and stall per step.
module tb_fwd_sel_ctrl;

  logic       clk;
  logic       reset_n;
  logic       stall;
  logic       flush;
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       load_use_stall;

  int n_assert = 0;
  int n_fail   = 0;

  fwd_sel_ctrl #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .flush          (flush),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_rd          (id_rd),
    .id_regwrite    (id_regwrite),
    .id_memread     (id_memread),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .load_use_stall (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic wr, input logic ld);
    id_rn       = rn;
    id_rm       = rm;
    id_rd       = rd;
    id_regwrite = wr;
    id_memread  = ld;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [1:0] a, input logic [1:0] b, input logic s);
    chk({tag, ".a"}, fwd_a_sel, a);
    chk({tag, ".b"}, fwd_b_sel, b);
    chk({tag, ".stall"}, {1'b0, load_use_stall}, {1'b0, s});
    $display("step %-14s a=%b b=%b stall=%b", tag, fwd_a_sel, fwd_b_sel, load_use_stall);
  endtask

  initial begin
    reset_n = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3;
    chk3("reset", 2'b00, 2'b00, 1'b0);
    step();
    reset_n = 1'b1;

    // Back-to-back ALU dependency
    set_id(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    step();
    set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
    step();
    chk3("b2b", 2'b01, 2'b00, 1'b0);

    // Distance-2 dependency
    set_id(5'd10, 5'd11, 5'd3, 1'b1, 1'b0);
    step();
    set_id(5'd12, 5'd13, 5'd8, 1'b1, 1'b0);
    step();
    set_id(5'd3, 5'd14, 5'd9, 1'b0, 1'b0);
    step();
    chk3("dist2", 2'b10, 2'b00, 1'b0);

    // rd=3 in both EX and MEM: EX wins
    set_id(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    step();
    set_id(5'd15, 5'd16, 5'd3, 1'b1, 1'b0);
    step();
    set_id(5'd17, 5'd3, 5'd0, 1'b0, 1'b0);
    step();
    chk3("priority", 2'b00, 2'b01, 1'b0);

    // Load-use on rm
    set_id(5'd18, 5'd19, 5'd4, 1'b1, 1'b1);
    step();
    set_id(5'd20, 5'd4, 5'd21, 1'b1, 1'b0);
    #1;
    chk3("ldu_req", 2'b00, 2'b00, 1'b1);
    step();
    chk3("ldu_bubble", 2'b00, 2'b00, 1'b0);
    step();
    chk3("ldu_fwd", 2'b00, 2'b10, 1'b0);

    // Zero register never forwards or stalls
    set_id(5'd0, 5'd0, 5'd31, 1'b1, 1'b1);
    step();
    set_id(5'd31, 5'd31, 5'd0, 1'b0, 1'b0);
    #1;
    chk3("zero_req", 2'b00, 2'b00, 1'b0);
    step();
    chk3("zero_sel", 2'b00, 2'b00, 1'b0);

    // Identical sources
    set_id(5'd0, 5'd0, 5'd22, 1'b1, 1'b0);
    step();
    set_id(5'd22, 5'd22, 5'd0, 1'b0, 1'b0);
    step();
    chk3("same_src", 2'b01, 2'b01, 1'b0);

    // Flush squashes the writer; MEM holds rd=22 so rn=22 would otherwise give 10
    set_id(5'd22, 5'd0, 5'd5, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk3("flush_sel", 2'b00, 2'b00, 1'b0);
    set_id(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk3("flush_rd", 2'b00, 2'b00, 1'b0);

    // Stall freezes all state
    set_id(5'd0, 5'd0, 5'd26, 1'b1, 1'b0);
    step();
    set_id(5'd26, 5'd0, 5'd6, 1'b1, 1'b0);
    step();
    chk3("pre_stall", 2'b01, 2'b00, 1'b0);
    set_id(5'd6, 5'd26, 5'd0, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk3($sformatf("stall%0d", i), 2'b01, 2'b00, 1'b0);
    end
    stall = 1'b0;
    step();
    chk3("stall_rel", 2'b01, 2'b10, 1'b0);

    // Stall and flush together: flush wins
    set_id(5'd6, 5'd0, 5'd27, 1'b1, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    step();
    stall = 1'b0;
    flush = 1'b0;
    chk3("sf_sel", 2'b00, 2'b00, 1'b0);
    set_id(5'd27, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk3("sf_rd", 2'b00, 2'b00, 1'b0);

    // Asynchronous reset mid-run discards hazard history
    set_id(5'd0, 5'd0, 5'd29, 1'b1, 1'b0);
    step();
    set_id(5'd29, 5'd29, 5'd28, 1'b1, 1'b1);
    step();
    chk3("pre_rst", 2'b01, 2'b01, 1'b0);
    set_id(5'd28, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk3("pre_rst_ldu", 2'b01, 2'b01, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk3("rst_async", 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk3($sformatf("rst_hold%0d", i), 2'b00, 2'b00, 1'b0);
    end
    reset_n = 1'b1;
    step();
    chk3("post_rst", 2'b00, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Forwarding-select controller for the in-order pipeline.
- Tracks the destination registers of the two instructions ahead of decode (EX and MEM stages).
- Compares them against the decode-stage source registers.
- Produces registered 2-bit select codes that drive the EX-stage operand mux trees, which are built from mux2_1 cells.
- Also detects load-use hazards and requests a one-cycle decode stall.

Parameters:
REG_W, 5, width of a register index
ZERO_REG, 31, hardwired-zero register index; never forwarded, never causes a hazard

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  external pipeline hold; all internal state frozen
flush  input  1  squash the instruction entering EX (branch taken)
id_rn  input  REG_W  decode-stage source A register
id_rm  input  REG_W  decode-stage source B register
id_rd  input  REG_W  decode-stage destination register
id_regwrite  input  1  decode instruction writes id_rd
id_memread  input  1  decode instruction is a load
fwd_a_sel  output  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result
fwd_b_sel  output  2  EX operand B select, same encoding
load_use_stall  output  1  combinational; decode must hold this cycle

Behaviour:
- Internal state:
  - EX slot: ex_rd, ex_wr, ex_ld.
  - MEM slot: mem_rd, mem_wr.
  - Registered fwd_a_sel and fwd_b_sel.
- Reset (reset_n=0, asynchronous):
  - All slot fields and both selects are 0.
  - With ex_wr=mem_wr=0, load_use_stall reads 0 immediately.
  - Reset asserted mid-operation discards all hazard history.
- Match rule:
  - src matches a slot iff slot_wr=1, slot_rd==src and src!=ZERO_REG.
- Select computation (combinational in ID, registered on the clock edge):
  - src matches the EX slot → 01.
  - Else src matches the MEM slot → 10.
  - Else → 00.
  - The EX slot (younger) has priority over MEM when both match.
- load_use_stall = ex_ld & ex_wr & (ex_rd==id_rn or ex_rd==id_rm) & matched src != ZERO_REG. It is purely combinational, with no latency.
- Clock-edge update, first matching case wins:
  1. flush=1 (takes priority over stall and load_use_stall):
     - EX slot ← bubble (wr=0, ld=0).
     - MEM ← old EX.
     - Selects ← 00.
  2. stall=1:
     - All state held, selects included.
  3. load_use_stall=1:
     - EX slot ← bubble.
     - MEM ← old EX.
     - Selects ← 00.
     - On the following cycle the load sits in MEM, so the dependent instruction gets select 10.
  4. Otherwise:
     - EX ← {id_rd, id_regwrite, id_memread}.
     - MEM ← {ex_rd, ex_wr}.
     - Selects ← computed values.
- Latency:
  - Selects are valid one cycle after the consuming instruction is in ID, i.e. while it is in EX.
- Identical sources: id_rn==id_rm yields identical A and B selects.
- A destination of ZERO_REG never produces a forward or a stall, even when its wr bit is 1.

Test Plan:
- Reset check: assert reset_n=0 mid-run with ex_wr=1 → fwd_a_sel=fwd_b_sel=00 and load_use_stall=0 immediately; all outputs stay 0 until reset_n=1.
- Back-to-back ALU dependency: ADD X1 (rd=1, wr=1) then SUB with rn=1, rm=2 → next edge fwd_a_sel=01, fwd_b_sel=00.
- Distance-2 dependency, plus priority: writer rd=3, one unrelated instruction, then rn=3 → fwd_a_sel=10. With rd=3 in both EX and MEM → 01.
- Load-use: LDUR rd=4 (memread=1) followed by rm=4 → load_use_stall=1 for exactly one cycle, selects 00 that edge; on the next edge fwd_b_sel=10.
- Zero register: writer rd=31, wr=1, followed by rn=31 and rm=31 → selects 00 and no stall.
- Flush and stall:
  - Writer rd=5 in ID with flush=1, then rn=5 → fwd_a_sel=00.
  - stall=1 for 3 cycles with rd=6 in EX → selects frozen; after release, a reader of 6 gets 01.
  - stall and flush both set → flush behaviour.
